// File: rtl/atmega_io_bus_master.sv
// Initiator for the ATmega-style I/O register bus: turns valid/ready commands into
// single-cycle rd_dat/wr_dat strobes, with read-modify-write and poll-until-match.
module atmega_io_bus_master #(
  parameter int unsigned BUS_ADDR_DATA_LEN = 8,
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned POLL_MAX          = 16,
  parameter int unsigned POLL_GAP          = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [BUS_ADDR_DATA_LEN-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]        cmd_data,
  input  logic [DATA_WIDTH-1:0]        cmd_mask,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic                         rsp_err,
  output logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
  output logic                         wr_dat,
  output logic                         rd_dat,
  output logic [DATA_WIDTH-1:0]        bus_dat_out,
  input  logic [DATA_WIDTH-1:0]        bus_dat_in
);

  localparam int unsigned AW       = BUS_ADDR_DATA_LEN;
  localparam int unsigned DW       = DATA_WIDTH;
  localparam int unsigned ATT_W    = $clog2(POLL_MAX + 1);
  localparam int unsigned GAP_W    = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam int unsigned GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

  localparam logic [2:0] OP_WRITE  = 3'd0;
  localparam logic [2:0] OP_READ   = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_CLR    = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_POLL   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_GAP  = 3'd3,
    S_RSP  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      data_q, data_d;
  logic [DW-1:0]      mask_q, mask_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [ATT_W-1:0]   attempt_q, attempt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [DW-1:0]      rsp_data_d;
  logic               rsp_err_d;
  logic               rsp_valid_d;
  logic               rd_dat_d;
  logic               wr_dat_d;
  logic [AW-1:0]      addr_dat_d;
  logic [DW-1:0]      bus_dat_out_d;

  assign cmd_ready = (state_q == S_IDLE) & ~rst;

  // State and registered bus/response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      wdata_q     <= '0;
      attempt_q   <= '0;
      gap_q       <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_valid   <= 1'b0;
      rd_dat      <= 1'b0;
      wr_dat      <= 1'b0;
      addr_dat    <= '0;
      bus_dat_out <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      wdata_q     <= wdata_d;
      attempt_q   <= attempt_d;
      gap_q       <= gap_d;
      rsp_data    <= rsp_data_d;
      rsp_err     <= rsp_err_d;
      rsp_valid   <= rsp_valid_d;
      rd_dat      <= rd_dat_d;
      wr_dat      <= wr_dat_d;
      addr_dat    <= addr_dat_d;
      bus_dat_out <= bus_dat_out_d;
    end
  end

  // Next-state and next-output decode; strobes follow the state being entered
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    data_d        = data_q;
    mask_d        = mask_q;
    wdata_d       = wdata_q;
    attempt_d     = attempt_q;
    gap_d         = gap_q;
    rsp_data_d    = rsp_data;
    rsp_err_d     = rsp_err;
    rsp_valid_d   = 1'b0;
    rd_dat_d      = 1'b0;
    wr_dat_d      = 1'b0;
    addr_dat_d    = '0;
    bus_dat_out_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op;
          addr_d     = cmd_addr;
          data_d     = cmd_data;
          mask_d     = cmd_mask;
          attempt_d  = '0;
          gap_d      = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          case (cmd_op)
            OP_WRITE: begin
              wdata_d = cmd_data;
              state_d = S_WR;
            end
            OP_READ, OP_SET, OP_CLR, OP_TOGGLE, OP_POLL: state_d = S_RD;
            default: begin
              rsp_err_d = 1'b1;
              state_d   = S_RSP;
            end
          endcase
        end
      end

      S_RD: begin
        rsp_data_d = bus_dat_in;
        attempt_d  = attempt_q + ATT_W'(1);
        case (op_q)
          OP_SET: begin
            wdata_d = bus_dat_in | data_q;
            state_d = S_WR;
          end
          OP_CLR: begin
            wdata_d = bus_dat_in & ~data_q;
            state_d = S_WR;
          end
          OP_TOGGLE: begin
            wdata_d = bus_dat_in ^ data_q;
            state_d = S_WR;
          end
          OP_POLL: begin
            if (((bus_dat_in ^ data_q) & mask_q) == '0) begin
              rsp_err_d = 1'b0;
              state_d   = S_RSP;
            end else if (attempt_d == ATT_W'(POLL_MAX)) begin
              rsp_err_d = 1'b1;
              state_d   = S_RSP;
            end else if (POLL_GAP == 0) begin
              state_d = S_RD;
            end else begin
              gap_d   = '0;
              state_d = S_GAP;
            end
          end
          default: state_d = S_RSP;
        endcase
      end

      S_WR: state_d = S_RSP;

      S_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) begin
          state_d = S_RD;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    rsp_valid_d = (state_d == S_RSP);
    rd_dat_d    = (state_d == S_RD);
    wr_dat_d    = (state_d == S_WR);
    if (state_d == S_RD || state_d == S_WR) begin
      addr_dat_d = addr_d;
    end
    if (state_d == S_WR) begin
      bus_dat_out_d = wdata_d;
    end
  end

endmodule

// File: tb/tb_atmega_io_bus_master.sv
// Directed bench for atmega_io_bus_master with POLL_MAX=3, POLL_GAP=2 and a
// combinational responder that only drives bus_dat_in while rd_dat is high.
module tb_atmega_io_bus_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [7:0] cmd_mask;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [7:0] addr_dat;
  logic       wr_dat;
  logic       rd_dat;
  logic [7:0] bus_dat_out;
  logic [7:0] bus_dat_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder model: fixed value, or in poll mode 0x01 from read index poll_hit on
  logic [7:0] fixed_val = 8'h00;
  logic       poll_mode = 1'b0;
  int         poll_hit  = 99;
  int         rd_cnt    = 0;
  logic       cnt_clr   = 1'b0;

  assign bus_dat_in = !rd_dat ? 8'h00 :
                      (poll_mode ? ((rd_cnt >= poll_hit) ? 8'h01 : 8'h00) : fixed_val);

  always @(posedge clk) begin
    if (cnt_clr) rd_cnt <= 0;
    else if (rd_dat) rd_cnt <= rd_cnt + 1;
  end

  always #5 clk = ~clk;

  atmega_io_bus_master #(
    .BUS_ADDR_DATA_LEN(8),
    .DATA_WIDTH(8),
    .POLL_MAX(3),
    .POLL_GAP(2)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .addr_dat(addr_dat), .wr_dat(wr_dat), .rd_dat(rd_dat),
    .bus_dat_out(bus_dat_out), .bus_dat_in(bus_dat_in)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command and return one cycle after the accepting edge (cycle T+1)
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] m);
    int waited;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: cmd_ready=%b required 1 within 20 cycles", cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic handshake(input string name);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_rsp_drop: rsp_valid=%b required 0", name, rsp_valid);
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_idle: cmd_ready=%b required 1", name, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd1; cmd_addr = 8'h11; cmd_data = 8'h22;
    cmd_mask = 8'h00; rsp_ready = 1'b0;
    repeat (3) step();
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready); end
    n_checks++;
    if ({rsp_valid, rsp_err, wr_dat, rd_dat} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: rsp_valid,err,wr,rd=%b required 0000",
                         {rsp_valid, rsp_err, wr_dat, rd_dat});
    end
    n_checks++;
    if ({rsp_data, addr_dat, bus_dat_out} !== 24'h0) begin
      n_fail++; $display("FAIL reset_data: rsp_data,addr,dout=%h required 000000",
                         {rsp_data, addr_dat, bus_dat_out});
    end
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready); end
  endtask

  task automatic test_write();
    issue(3'd0, 8'h23, 8'h5A, 8'h00);
    n_checks++;
    if ({wr_dat, rd_dat, addr_dat, bus_dat_out} !== {2'b10, 8'h23, 8'h5A}) begin
      n_fail++; $display("FAIL write_strobe: wr=%b rd=%b addr=%h dout=%h required 1 0 23 5a",
                         wr_dat, rd_dat, addr_dat, bus_dat_out);
    end
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL write_early_rsp: rsp_valid=%b required 0", rsp_valid); end
    step();
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data, wr_dat, addr_dat, bus_dat_out} !== {2'b10, 8'h00, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL write_rsp: valid=%b err=%b data=%h wr=%b addr=%h dout=%h required 1 0 00 0 00 00",
                         rsp_valid, rsp_err, rsp_data, wr_dat, addr_dat, bus_dat_out);
    end
    handshake("write");
  endtask

  task automatic test_read_stall();
    fixed_val = 8'hA5;
    issue(3'd1, 8'h24, 8'h00, 8'h00);
    n_checks++;
    if ({rd_dat, wr_dat, addr_dat, bus_dat_out} !== {2'b10, 8'h24, 8'h00}) begin
      n_fail++; $display("FAIL read_strobe: rd=%b wr=%b addr=%h dout=%h required 1 0 24 00",
                         rd_dat, wr_dat, addr_dat, bus_dat_out);
    end
    step();
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data, rd_dat} !== {2'b10, 8'hA5, 1'b0}) begin
      n_fail++; $display("FAIL read_rsp: valid=%b err=%b data=%h rd=%b required 1 0 a5 0",
                         rsp_valid, rsp_err, rsp_data, rd_dat);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({rsp_valid, rsp_data, cmd_ready, rd_dat, wr_dat, addr_dat} !== {1'b1, 8'hA5, 3'b000, 8'h00}) begin
        n_fail++; $display("FAIL read_stall%0d: valid=%b data=%h cmd_ready=%b rd=%b wr=%b addr=%h required 1 a5 0 0 0 00",
                           i, rsp_valid, rsp_data, cmd_ready, rd_dat, wr_dat, addr_dat);
      end
    end
    handshake("read");
  endtask

  task automatic test_rmw(input string name, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] rdv, input logic [7:0] d, input logic [7:0] exp_w);
    fixed_val = rdv;
    issue(op, a, d, 8'h00);
    n_checks++;
    if ({rd_dat, wr_dat, addr_dat} !== {2'b10, a}) begin
      n_fail++; $display("FAIL %s_rd: rd=%b wr=%b addr=%h required 1 0 %h", name, rd_dat, wr_dat, addr_dat, a);
    end
    step();
    n_checks++;
    if ({wr_dat, rd_dat, addr_dat, bus_dat_out, rsp_valid} !== {2'b10, a, exp_w, 1'b0}) begin
      n_fail++; $display("FAIL %s_wr: wr=%b rd=%b addr=%h dout=%h rsp_valid=%b required 1 0 %h %h 0",
                         name, wr_dat, rd_dat, addr_dat, bus_dat_out, rsp_valid, a, exp_w);
    end
    step();
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data, wr_dat} !== {2'b10, rdv, 1'b0}) begin
      n_fail++; $display("FAIL %s_rsp: valid=%b err=%b data=%h wr=%b required 1 0 %h 0",
                         name, rsp_valid, rsp_err, rsp_data, wr_dat, rdv);
    end
    handshake(name);
  endtask

  // Runs a POLL and checks read spacing, first-response cycle and result
  task automatic test_poll(input string name, input int hit, input int exp_reads,
                           input int exp_rsp_cyc, input logic exp_err, input logic [7:0] exp_data);
    int rd_cycles[$];
    int cyc;
    poll_mode = 1'b1; poll_hit = hit;
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    issue(3'd5, 8'h30, 8'h01, 8'h01);
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      if (rd_dat === 1'b1) rd_cycles.push_back(cyc);
      n_checks++;
      if (wr_dat !== 1'b0 || (rd_dat !== 1'b1 && addr_dat !== 8'h00) || (rd_dat === 1'b1 && addr_dat !== 8'h30)) begin
        n_fail++; $display("FAIL %s_bus_c%0d: wr=%b rd=%b addr=%h required wr 0, addr 30 only with rd",
                           name, cyc, wr_dat, rd_dat, addr_dat);
      end
      step();
      cyc++;
    end
    n_checks++;
    if (cyc !== exp_rsp_cyc) begin
      n_fail++; $display("FAIL %s_latency: rsp at T+%0d required T+%0d", name, cyc, exp_rsp_cyc);
    end
    n_checks++;
    if (rd_cycles.size() !== exp_reads) begin
      n_fail++; $display("FAIL %s_reads: %0d rd pulses required %0d", name, rd_cycles.size(), exp_reads);
    end
    for (int i = 0; i < rd_cycles.size(); i++) begin
      n_checks++;
      if (rd_cycles[i] !== 1 + 3 * i) begin
        n_fail++; $display("FAIL %s_rd%0d_pos: at T+%0d required T+%0d", name, i, rd_cycles[i], 1 + 3 * i);
      end
    end
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, exp_err, exp_data}) begin
      n_fail++; $display("FAIL %s_rsp: valid=%b err=%b data=%h required 1 %b %h",
                         name, rsp_valid, rsp_err, rsp_data, exp_err, exp_data);
    end
    handshake(name);
    poll_mode = 1'b0;
  endtask

  task automatic test_reset_mid_rmw();
    fixed_val = 8'h0F;
    issue(3'd2, 8'h20, 8'hF0, 8'h00);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({wr_dat, rd_dat, rsp_valid, cmd_ready, bus_dat_out} !== {4'b0000, 8'h00}) begin
        n_fail++; $display("FAIL midrst_hold%0d: wr=%b rd=%b rsp_valid=%b cmd_ready=%b dout=%h required 0 0 0 0 00",
                           i, wr_dat, rd_dat, rsp_valid, cmd_ready, bus_dat_out);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({wr_dat, rd_dat, rsp_valid, cmd_ready} !== 4'b0001) begin
        n_fail++; $display("FAIL midrst_after%0d: wr=%b rd=%b rsp_valid=%b cmd_ready=%b required 0 0 0 1",
                           i, wr_dat, rd_dat, rsp_valid, cmd_ready);
      end
    end
  endtask

  task automatic test_illegal();
    issue(3'd7, 8'h40, 8'h55, 8'h00);
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data, rd_dat, wr_dat, addr_dat} !== {2'b11, 8'h00, 2'b00, 8'h00}) begin
      n_fail++; $display("FAIL illegal_rsp: valid=%b err=%b data=%h rd=%b wr=%b addr=%h required 1 1 00 0 0 00",
                         rsp_valid, rsp_err, rsp_data, rd_dat, wr_dat, addr_dat);
    end
    handshake("illegal");
  endtask

  // Second command presented while the first response is still being handshaked
  task automatic test_back_to_back();
    fixed_val = 8'h3C;
    issue(3'd1, 8'h25, 8'h00, 8'h00);
    step();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_addr = 8'h26; cmd_data = 8'hC3; cmd_mask = 8'h00;
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_rsp: cmd_ready=%b required 0", cmd_ready); end
    step();
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, cmd_ready, wr_dat} !== 3'b010) begin
      n_fail++; $display("FAIL b2b_idle: rsp_valid=%b cmd_ready=%b wr=%b required 0 1 0", rsp_valid, cmd_ready, wr_dat);
    end
    step();
    cmd_valid = 1'b0;
    n_checks++;
    if ({wr_dat, addr_dat, bus_dat_out} !== {1'b1, 8'h26, 8'hC3}) begin
      n_fail++; $display("FAIL b2b_write: wr=%b addr=%h dout=%h required 1 26 c3", wr_dat, addr_dat, bus_dat_out);
    end
    step();
    handshake("b2b");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_rmw("set",    3'd2, 8'h20, 8'h0F, 8'hF0, 8'hFF);
    test_rmw("clr",    3'd3, 8'h21, 8'hFF, 8'h0F, 8'hF0);
    test_rmw("toggle", 3'd4, 8'h22, 8'hAA, 8'hFF, 8'h55);
    test_poll("poll_timeout", 99, 3, 8, 1'b1, 8'h00);
    test_poll("poll_match",    1, 2, 5, 1'b0, 8'h01);
    test_reset_mid_rmw();
    test_illegal();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
